// File: rtl/la_pwrseq.sv
// rtl/la_pwrseq.sv - power-domain sequencer: orders power-switch enable against boundary isolation.
// Optional pwr_good timeout and FAULT state: define LA_PWRSEQ_TIMEOUT_EN.
module la_pwrseq #(
    parameter int CW      = 8,
    parameter int PWR_DLY = 16,
    parameter int ISO_DLY = 4,
    parameter int TO_DLY  = 255
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pwr_req,
    input  logic       i_pwr_good,
    output logic       o_pwr_en,
    output logic       o_iso,
    output logic       o_pwr_ack,
    output logic       o_busy,
    output logic [2:0] o_state,
    output logic       o_fault
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWRUP  = 3'd1,
        S_ISOREL = 3'd2,
        S_ON     = 3'd3,
        S_ISOSET = 3'd4,
        S_PWRDN  = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [CW-1:0] L_PWR  = CW'(PWR_DLY);
    localparam logic [CW-1:0] L_ISO  = CW'(ISO_DLY);
    localparam logic [CW-1:0] L_ZERO = '0;
    localparam logic [CW-1:0] L_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_pwr_en;
    logic          r_iso;

`ifdef LA_PWRSEQ_TIMEOUT_EN
    localparam logic [CW-1:0] L_TO = CW'(TO_DLY);
    logic [CW-1:0] r_to;
    logic [CW-1:0] w_to_next;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = (r_cnt != L_ZERO) ? r_cnt - L_ONE : r_cnt;
`ifdef LA_PWRSEQ_TIMEOUT_EN
        w_to_next  = (r_to != L_ZERO) ? r_to - L_ONE : r_to;
`endif
        case (r_state)
            S_OFF: begin
                if (i_pwr_req) begin
                    w_next     = S_PWRUP;
                    w_cnt_next = L_PWR;
`ifdef LA_PWRSEQ_TIMEOUT_EN
                    w_to_next  = L_TO;
`endif
                end
            end
            // Abort is checked first so a late pwr_req drop never releases iso.
            S_PWRUP: begin
                if (!i_pwr_req) begin
                    w_next     = S_PWRDN;
                    w_cnt_next = L_PWR;
                end else if (r_cnt == L_ZERO && i_pwr_good) begin
                    w_next     = S_ISOREL;
                    w_cnt_next = L_ISO;
                end
`ifdef LA_PWRSEQ_TIMEOUT_EN
                else if (r_to == L_ZERO) begin
                    w_next = S_FAULT;
                end
`endif
            end
            S_ISOREL: begin
                if (!i_pwr_req) begin
                    w_next     = S_PWRDN;
                    w_cnt_next = L_PWR;
                end else if (r_cnt == L_ZERO) begin
                    w_next = S_ON;
                end
            end
            S_ON: begin
                if (!i_pwr_req) begin
                    w_next     = S_ISOSET;
                    w_cnt_next = L_ISO;
                end
            end
            S_ISOSET: begin
                if (r_cnt == L_ZERO) begin
                    w_next     = S_PWRDN;
                    w_cnt_next = L_PWR;
                end
            end
            S_PWRDN: begin
                if (r_cnt == L_ZERO) w_next = S_OFF;
            end
            S_FAULT: begin
                if (!i_pwr_req) w_next = S_OFF;
            end
            default: w_next = S_OFF;
        endcase
    end

    // pwr_en/iso are registered from the next-state decode so they change on the same edge as state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_OFF;
            r_cnt    <= L_ZERO;
            r_pwr_en <= 1'b0;
            r_iso    <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_pwr_en <= (w_next == S_PWRUP) || (w_next == S_ISOREL) ||
                        (w_next == S_ON)    || (w_next == S_ISOSET);
            r_iso    <= (w_next != S_ON);
        end
    end

`ifdef LA_PWRSEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_to <= L_ZERO;
        else         r_to <= w_to_next;
    end
    assign o_fault = (r_state == S_FAULT);
`else
    assign o_fault = 1'b0;
`endif

    assign o_pwr_en  = r_pwr_en;
    assign o_iso     = r_iso;
    assign o_pwr_ack = (r_state == S_ON);
    assign o_busy    = (r_state == S_PWRUP)  || (r_state == S_ISOREL) ||
                       (r_state == S_ISOSET) || (r_state == S_PWRDN);
    assign o_state   = r_state;

endmodule

// File: tb/tb_la_pwrseq.sv
// tb/tb_la_pwrseq.sv - self-checking bench for la_pwrseq (PWR_DLY=4 ISO_DLY=2 TO_DLY=10).
module tb_la_pwrseq;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       good;
    logic       pwr_en, iso, pwr_ack, busy, fault;
    logic [2:0] state;

    localparam logic [2:0] OFF = 3'd0, PWRUP = 3'd1, ISOREL = 3'd2, ON = 3'd3,
                           ISOSET = 3'd4, PWRDN = 3'd5, FAULT = 3'd6;

    la_pwrseq #(.CW(8), .PWR_DLY(4), .ISO_DLY(2), .TO_DLY(10)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_pwr_req  (req),
        .i_pwr_good (good),
        .o_pwr_en   (pwr_en),
        .o_iso      (iso),
        .o_pwr_ack  (pwr_ack),
        .o_busy     (busy),
        .o_state    (state),
        .o_fault    (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic       good;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        int         tag;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag      = 0;

    // Expected {pwr_en, iso, pwr_ack, busy, fault} for each state.
    function automatic logic [4:0] dec(input logic [2:0] s);
        case (s)
            OFF:     dec = 5'b01000;
            PWRUP:   dec = 5'b11010;
            ISOREL:  dec = 5'b11010;
            ON:      dec = 5'b10100;
            ISOSET:  dec = 5'b11010;
            PWRDN:   dec = 5'b01010;
            FAULT:   dec = 5'b01001;
            default: dec = 5'b01000;
        endcase
    endfunction

    task automatic compare(input int t, input logic [2:0] st);
        logic [7:0] got, want;
        got  = {state, pwr_en, iso, pwr_ack, busy, fault};
        want = {st, dec(st)};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL step%0d got state=%0d en/iso/ack/busy/fault=%b want state=%0d en/iso/ack/busy/fault=%b",
                     t, got[7:5], got[4:0], want[7:5], want[4:0]);
        end
    endtask

    task automatic step(input logic r, input logic g, input logic [2:0] st);
        exp_t e;
        req  = r;
        good = g;
        sb.push_back('{st: st, tag: tag});
        tag++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(e.tag, e.st);
    endtask

    task automatic rep(input int n, input logic r, input logic g, input logic [2:0] st);
        for (int i = 0; i < n; i++) step(r, g, st);
    endtask

    task automatic power_up_to_on();
        rep(5, 1'b1, 1'b1, PWRUP);
        rep(3, 1'b1, 1'b1, ISOREL);
        step(1'b1, 1'b1, ON);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, PWRUP};
        vecs[1]  = '{1'b1, 1'b1, PWRUP};
        vecs[2]  = '{1'b1, 1'b1, PWRUP};
        vecs[3]  = '{1'b1, 1'b1, PWRUP};
        vecs[4]  = '{1'b1, 1'b1, PWRUP};
        vecs[5]  = '{1'b1, 1'b1, ISOREL};
        vecs[6]  = '{1'b1, 1'b1, ISOREL};
        vecs[7]  = '{1'b1, 1'b1, ISOREL};
        vecs[8]  = '{1'b1, 1'b1, ON};
        vecs[9]  = '{1'b1, 1'b0, ON};
        vecs[10] = '{1'b0, 1'b1, ISOSET};
        vecs[11] = '{1'b0, 1'b1, ISOSET};
        vecs[12] = '{1'b0, 1'b1, ISOSET};
        vecs[13] = '{1'b0, 1'b1, PWRDN};
        vecs[14] = '{1'b1, 1'b1, PWRDN};
        vecs[15] = '{1'b0, 1'b1, PWRDN};
        vecs[16] = '{1'b1, 1'b1, PWRDN};
        vecs[17] = '{1'b0, 1'b1, PWRDN};
        vecs[18] = '{1'b0, 1'b1, OFF};
        vecs[19] = '{1'b0, 1'b1, OFF};

        reset = 1'b1;
        req   = 1'b0;
        good  = 1'b0;
        #12;
        compare(-1, OFF);
        @(negedge clk);
        reset = 1'b0;

        // Full up/down sequence, one row per clock edge.
        for (int i = 0; i < 20; i++) step(vecs[i].req, vecs[i].good, vecs[i].st);

        // Async reset between edges while ON.
        power_up_to_on();
        #2;
        reset = 1'b1;
        #1;
        compare(-2, OFF);
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        step(1'b0, 1'b1, OFF);

        // Abort from PWRUP.
        rep(2, 1'b1, 1'b1, PWRUP);
        step(1'b0, 1'b1, PWRDN);
        rep(4, 1'b0, 1'b1, PWRDN);
        step(1'b0, 1'b1, OFF);

        // Abort from ISOREL once its counter has reached 0: abort wins.
        rep(5, 1'b1, 1'b1, PWRUP);
        rep(3, 1'b1, 1'b1, ISOREL);
        step(1'b0, 1'b1, PWRDN);
        rep(4, 1'b0, 1'b1, PWRDN);
        step(1'b0, 1'b1, OFF);

`ifdef LA_PWRSEQ_TIMEOUT_EN
        rep(11, 1'b1, 1'b0, PWRUP);
        rep(2, 1'b1, 1'b0, FAULT);
        step(1'b0, 1'b0, OFF);
        step(1'b0, 1'b0, OFF);
`else
        // Without the timeout PWRUP waits on pwr_good indefinitely.
        rep(21, 1'b1, 1'b0, PWRUP);
        step(1'b1, 1'b1, ISOREL);
        step(1'b0, 1'b1, PWRDN);
        rep(4, 1'b0, 1'b1, PWRDN);
        step(1'b0, 1'b1, OFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
